// File: rtl/mmu_xlate.sv
// Multi-channel registered virtual-to-physical translator: fixed kseg0/kseg1 segment
// mapping plus a shared fully associative 4 KiB page table for the mapped segments.
`timescale 1ns/1ps
module mmu_xlate #(
    parameter int CHANNELS = 2,
    parameter int ENTRIES  = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    map_en,
    input  logic [CHANNELS-1:0]     req_valid,
    output logic [CHANNELS-1:0]     req_ready,
    input  logic [32*CHANNELS-1:0]  req_vaddr,
    output logic [CHANNELS-1:0]     resp_valid,
    input  logic [CHANNELS-1:0]     resp_ready,
    output logic [32*CHANNELS-1:0]  resp_paddr,
    output logic [CHANNELS-1:0]     resp_uncached,
    output logic [CHANNELS-1:0]     resp_miss,
    input  logic                    tlbw_en,
    input  logic [19:0]             tlbw_vpn,
    input  logic [19:0]             tlbw_pfn,
    input  logic                    tlbw_cached,
    input  logic                    tlb_flush
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(ENTRIES - 1);

    logic [ENTRIES-1:0] valid_r;
    logic [ENTRIES-1:0] cached_r;
    logic [19:0]        vpn_r [ENTRIES];
    logic [19:0]        pfn_r [ENTRIES];
    logic [PW-1:0]      ptr_r;

    logic               wr_hit_s;
    logic [PW-1:0]      wr_idx_s;
    logic [PW-1:0]      wr_sel_s;
    logic [PW-1:0]      ptr_next_s;

    // Find an existing valid entry holding the VPN being written (at most one can match).
    always_comb begin
        wr_hit_s = 1'b0;
        wr_idx_s = {PW{1'b0}};
        for (int e = 0; e < ENTRIES; e++) begin
            wr_hit_s = wr_hit_s | (valid_r[e] & (vpn_r[e] == tlbw_vpn));
            wr_idx_s = wr_idx_s | (PW'(e) & {PW{valid_r[e] & (vpn_r[e] == tlbw_vpn)}});
        end
    end

    // Choose the write slot and the wrapped replacement pointer.
    always_comb begin
        wr_sel_s   = wr_hit_s ? wr_idx_s : ptr_r;
        ptr_next_s = (ptr_r == PTR_LAST) ? {PW{1'b0}} : (ptr_r + PW'(1));
    end

    // Table state: flush beats a same-cycle write; an update in place keeps the pointer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r  <= {ENTRIES{1'b0}};
            cached_r <= {ENTRIES{1'b0}};
            ptr_r    <= {PW{1'b0}};
            for (int e = 0; e < ENTRIES; e++) begin
                vpn_r[e] <= 20'h00000;
                pfn_r[e] <= 20'h00000;
            end
        end else if (tlb_flush) begin
            valid_r <= {ENTRIES{1'b0}};
            ptr_r   <= {PW{1'b0}};
        end else if (tlbw_en) begin
            vpn_r[wr_sel_s]    <= tlbw_vpn;
            pfn_r[wr_sel_s]    <= tlbw_pfn;
            cached_r[wr_sel_s] <= tlbw_cached;
            valid_r[wr_sel_s]  <= 1'b1;
            if (!wr_hit_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [31:0] va_s;
        logic        hit_s;
        logic [19:0] pfn_s;
        logic        cached_s;
        logic [31:0] paddr_s;
        logic        unc_s;
        logic        miss_s;
        logic        accept_s;
        logic        valid_q_r;
        logic [31:0] paddr_r;
        logic        unc_r;
        logic        miss_r;

        assign va_s     = req_vaddr[32*c +: 32];
        assign accept_s = req_valid[c] & req_ready[c];

        // Parallel compare against every valid entry; OR-merge is safe as matches are unique.
        always_comb begin
            hit_s    = 1'b0;
            pfn_s    = 20'h00000;
            cached_s = 1'b0;
            for (int e = 0; e < ENTRIES; e++) begin
                hit_s    = hit_s    | (valid_r[e] & (vpn_r[e] == va_s[31:12]));
                pfn_s    = pfn_s    | (pfn_r[e] & {20{valid_r[e] & (vpn_r[e] == va_s[31:12])}});
                cached_s = cached_s | (cached_r[e] & valid_r[e] & (vpn_r[e] == va_s[31:12]));
            end
        end

        // Segment decode and result selection for this channel.
        always_comb begin
            paddr_s = 32'h0000_0000;
            unc_s   = 1'b0;
            miss_s  = 1'b0;
            case (va_s[31:29])
                3'b100: begin
                    paddr_s = {3'b000, va_s[28:0]};
                    unc_s   = 1'b0;
                end
                3'b101: begin
                    paddr_s = {3'b000, va_s[28:0]};
                    unc_s   = 1'b1;
                end
                default: begin
                    if (!map_en) begin
                        paddr_s = va_s;
                    end else if (hit_s) begin
                        paddr_s = {pfn_s, va_s[11:0]};
                        unc_s   = ~cached_s;
                    end else begin
                        miss_s  = 1'b1;
                    end
                end
            endcase
        end

        // One-entry output register; holds while the consumer stalls.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                valid_q_r <= 1'b0;
                paddr_r   <= 32'h0000_0000;
                unc_r     <= 1'b0;
                miss_r    <= 1'b0;
            end else if (accept_s) begin
                valid_q_r <= 1'b1;
                paddr_r   <= paddr_s;
                unc_r     <= unc_s;
                miss_r    <= miss_s;
            end else if (resp_ready[c]) begin
                valid_q_r <= 1'b0;
            end
        end

        assign req_ready[c]            = ~valid_q_r | resp_ready[c];
        assign resp_valid[c]           = valid_q_r;
        assign resp_paddr[32*c +: 32]  = paddr_r;
        assign resp_uncached[c]        = unc_r;
        assign resp_miss[c]            = miss_r;
    end

endmodule

// File: tb/tb_mmu_xlate.sv
// Directed self-checking bench for mmu_xlate (CHANNELS=2, ENTRIES=8).
`timescale 1ns/1ps
module tb_mmu_xlate;

    logic        clk = 1'b0;
    logic        resetn;
    logic        map_en;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_vaddr;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_paddr;
    logic [1:0]  resp_uncached;
    logic [1:0]  resp_miss;
    logic        tlbw_en;
    logic [19:0] tlbw_vpn;
    logic [19:0] tlbw_pfn;
    logic        tlbw_cached;
    logic        tlb_flush;

    int n_cmp = 0;
    int n_err = 0;

    mmu_xlate #(.CHANNELS(2), .ENTRIES(8)) dut (
        .clk(clk), .resetn(resetn), .map_en(map_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_uncached(resp_uncached), .resp_miss(resp_miss),
        .tlbw_en(tlbw_en), .tlbw_vpn(tlbw_vpn), .tlbw_pfn(tlbw_pfn),
        .tlbw_cached(tlbw_cached), .tlb_flush(tlb_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input int ch, input logic [31:0] va);
        req_valid = 2'b00;
        req_valid[ch] = 1'b1;
        req_vaddr[32*ch +: 32] = va;
        tick();
        req_valid = 2'b00;
    endtask

    task automatic tlbw(input logic [19:0] vpn, input logic [19:0] pfn, input logic cached);
        tlbw_en = 1'b1;
        tlbw_vpn = vpn;
        tlbw_pfn = pfn;
        tlbw_cached = cached;
        tick();
        tlbw_en = 1'b0;
    endtask

    task automatic flush();
        tlb_flush = 1'b1;
        tick();
        tlb_flush = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input int ch, input logic [31:0] pa,
                               input logic unc, input logic miss);
        chk({tag, ".valid"}, 32'(resp_valid[ch]), 32'd1);
        chk({tag, ".paddr"}, resp_paddr[32*ch +: 32], pa);
        chk({tag, ".unc"}, 32'(resp_uncached[ch]), 32'(unc));
        chk({tag, ".miss"}, 32'(resp_miss[ch]), 32'(miss));
    endtask

    initial begin
        resetn = 1'b0;
        map_en = 1'b0;
        req_valid = 2'b00;
        req_vaddr = 64'h0;
        resp_ready = 2'b11;
        tlbw_en = 1'b0;
        tlbw_vpn = 20'h0;
        tlbw_pfn = 20'h0;
        tlbw_cached = 1'b0;
        tlb_flush = 1'b0;
        #12;
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.paddr", resp_paddr[31:0] | resp_paddr[63:32], 32'd0);
        chk("rst.unc", 32'(resp_uncached), 32'd0);
        chk("rst.miss", 32'(resp_miss), 32'd0);
        resp_ready = 2'b00;
        #1;
        chk("rst.ready", 32'(req_ready), 32'd3);
        resp_ready = 2'b11;
        #2;
        resetn = 1'b1;
        tick();

        // Both unmapped segments on both channels in one cycle
        req_valid = 2'b11;
        req_vaddr = {32'h8000_1234, 32'hBFC0_0000};
        tick();
        req_valid = 2'b00;
        expect_resp("kseg1", 0, 32'h1FC0_0000, 1'b1, 1'b0);
        expect_resp("kseg0", 1, 32'h0000_1234, 1'b0, 1'b0);
        tick();
        chk("drain.valid", 32'(resp_valid), 32'd0);

        // Legacy pass-through of mapped segments
        lookup(0, 32'h0040_0010);
        expect_resp("legacy.kuseg", 0, 32'h0040_0010, 1'b0, 1'b0);
        lookup(1, 32'hC000_1000);
        expect_resp("legacy.kseg2", 1, 32'hC000_1000, 1'b0, 1'b0);

        // Mapped: miss on empty table, then hit after install
        map_en = 1'b1;
        lookup(0, 32'h0040_0010);
        expect_resp("empty.miss", 0, 32'h0000_0000, 1'b0, 1'b1);
        tlbw(20'h00400, 20'h12345, 1'b1);
        lookup(0, 32'h0040_0010);
        expect_resp("hit.ch0", 0, 32'h1234_5010, 1'b0, 1'b0);
        lookup(1, 32'h0040_0FFF);
        expect_resp("hit.ch1", 1, 32'h1234_5FFF, 1'b0, 1'b0);
        tlbw(20'hC0000, 20'h00ABC, 1'b0);
        lookup(0, 32'hC000_0FFC);
        expect_resp("hit.unc", 0, 32'h00AB_CFFC, 1'b1, 1'b0);

        // Replacement: 9 writes into 8 entries evict the first
        flush();
        for (int i = 1; i <= 9; i++) begin
            tlbw(20'h10000 + 20'(i), 20'h20000 + 20'(i), 1'b1);
        end
        lookup(0, 32'h1000_1000);
        expect_resp("repl.evicted", 0, 32'h0000_0000, 1'b0, 1'b1);
        for (int i = 2; i <= 9; i++) begin
            logic [19:0] v;
            logic [19:0] p;
            v = 20'h10000 + 20'(i);
            p = 20'h20000 + 20'(i);
            lookup(0, {v, 12'h456});
            expect_resp("repl.hit", 0, {p, 12'h456}, 1'b0, 1'b0);
        end
        tlbw(20'h10005, 20'h3AAAA, 1'b1);
        lookup(1, 32'h1000_5ABC);
        expect_resp("update.inplace", 1, 32'h3AAA_AABC, 1'b0, 1'b0);
        // Pointer must still be 1: the next new VPN evicts VPN 2, not VPN 3
        tlbw(20'h1000A, 20'h2000A, 1'b1);
        lookup(0, 32'h1000_2000);
        expect_resp("ptr.vpn2_gone", 0, 32'h0000_0000, 1'b0, 1'b1);
        lookup(0, 32'h1000_3000);
        expect_resp("ptr.vpn3_kept", 0, 32'h2000_3000, 1'b0, 1'b0);
        lookup(0, 32'h1000_A000);
        expect_resp("ptr.vpn10", 0, 32'h2000_A000, 1'b0, 1'b0);

        // Backpressure on channel 1 while channel 0 streams
        resp_ready = 2'b01;
        req_valid[1] = 1'b1;
        req_vaddr[63:32] = 32'h8000_0100;
        tick();
        req_vaddr[63:32] = 32'h8000_0200;
        for (int k = 0; k < 3; k++) begin
            req_valid[0] = 1'b1;
            req_vaddr[31:0] = 32'h8000_0010 + 32'(k * 4);
            #1;
            chk("bp.req_ready1", 32'(req_ready[1]), 32'd0);
            tick();
            chk("bp.valid1", 32'(resp_valid[1]), 32'd1);
            chk("bp.paddr1", resp_paddr[63:32], 32'h0000_0100);
            chk("bp.stream0", resp_paddr[31:0], 32'h0000_0010 + 32'(k * 4));
            chk("bp.valid0", 32'(resp_valid[0]), 32'd1);
        end
        req_valid[0] = 1'b0;
        resp_ready = 2'b11;
        #1;
        chk("bp.release", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("bp.next1", resp_paddr[63:32], 32'h0000_0200);
        tick();

        // Write and lookup of the same VPN in one cycle
        flush();
        tlbw_en = 1'b1;
        tlbw_vpn = 20'h00777;
        tlbw_pfn = 20'h0ABCD;
        tlbw_cached = 1'b1;
        req_valid[0] = 1'b1;
        req_vaddr[31:0] = 32'h0077_7123;
        tick();
        tlbw_en = 1'b0;
        req_valid = 2'b00;
        expect_resp("same.miss", 0, 32'h0000_0000, 1'b0, 1'b1);
        lookup(0, 32'h0077_7123);
        expect_resp("same.hit", 0, 32'h0ABC_D123, 1'b0, 1'b0);

        // Flush wins over a simultaneous write
        tlb_flush = 1'b1;
        tlbw_en = 1'b1;
        tlbw_vpn = 20'h00888;
        tlbw_pfn = 20'h0CAFE;
        tick();
        tlb_flush = 1'b0;
        tlbw_en = 1'b0;
        lookup(0, 32'h0077_7123);
        expect_resp("flush.old", 0, 32'h0000_0000, 1'b0, 1'b1);
        lookup(1, 32'h0088_8000);
        expect_resp("flush.dropped", 1, 32'h0000_0000, 1'b0, 1'b1);

        // Reset during a pending response
        tlbw(20'h00999, 20'h0ABCE, 1'b1);
        resp_ready = 2'b00;
        lookup(0, 32'h0099_9000);
        expect_resp("pre_rst", 0, 32'h0ABC_E000, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst.valid", 32'(resp_valid), 32'd0);
        chk("async_rst.paddr", resp_paddr[31:0], 32'd0);
        #3;
        resetn = 1'b1;
        resp_ready = 2'b11;
        tick();
        lookup(0, 32'h0099_9000);
        expect_resp("post_rst.miss", 0, 32'h0000_0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
